ex_pipe_unit: RTL and testbench
===============================

EX_PIPE_UNIT -- requirements
Module: ex_pipe_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, which sets the datapath width in bits (legal values 8 to 32).
REQ-002 The block SHALL have parameter MUL_EN, default 1: 1 SHALL enable the iterative multiply; 0 SHALL make opcode MUL behave as PASS.
REQ-003 The block SHALL have port clk, input, width 1: the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rst_n, input, width 1: asynchronous, active-low reset.
REQ-005 The block SHALL have port in_valid, input, width 1: the ID/EX operation is presented this cycle.
REQ-006 The block SHALL have port in_ready, output, width 1: the block accepts the operation this cycle.
REQ-007 The block SHALL have ports pc_in, reg_a, reg_b and imm, input, width WIDTH each: PC, register A, register B and immediate.
REQ-008 The block SHALL have port opcode, input, width 4: ALU operation.
REQ-009 The block SHALL have port alu_src, input, width 1: 1 selects forwarded B as in2; 0 selects imm.
REQ-010 The block SHALL have port pc_switch, input, width 1: 1 selects pc_in as in1; 0 selects forwarded A.
REQ-011 The block SHALL have ports fwd_a and fwd_b, input, width 2: forwarding select for operands A and B.
REQ-012 The block SHALL have ports mem_fwd and wb_fwd, input, width WIDTH each: MEM-stage and WB-stage forwarded data.
REQ-013 The block SHALL have port stall_in, input, width 1: downstream cannot take a result.
REQ-014 The block SHALL have port flush, input, width 1: kill in-flight and registered results.
REQ-015 The block SHALL have port out_valid, output, width 1: alu_out is a valid EX/MEM result.
REQ-016 The block SHALL have port alu_out, output, width WIDTH: registered result.
REQ-017 The block SHALL have port flags, output, width 3: registered {Z,V,N}.
REQ-018 The block SHALL have port busy, output, width 1: a multiply is in progress.

Function
REQ-019 Operand forwarding SHALL resolve by fwd value: 2'b1x selects mem_fwd, 2'b01 selects wb_fwd and 2'b00 selects the register value (mem_fwd has priority).
REQ-020 Opcodes SHALL be: 0 ADD, 1 SUB, 2 XOR, 3 AND, 4 OR, 5 SLL, 6 SRA, 7 ROR, 8 MUL, 9-15 PASS (alu_out = in2).
REQ-021 ADD and SUB SHALL saturate as two's complement: positive overflow gives the maximum positive value, negative overflow gives the minimum negative value, and V=1 in either case.
REQ-022 Shift amount SHALL be in2[log2(WIDTH)-1:0]; an amount of 0 SHALL return in1 unchanged.
REQ-023 MUL SHALL produce the low WIDTH bits of the unsigned product in1*in2 by shift-add, one partial product per cycle.
REQ-024 Flag update: ADD/SUB SHALL update Z,V,N; XOR/AND/OR/SLL/SRA/ROR/MUL SHALL update Z only; PASS SHALL update no flag.
REQ-025 The flags SHALL update at the same edge at which the result is registered.
REQ-026 in_ready SHALL equal ~busy & ~(out_valid & stall_in); an operation SHALL be accepted when in_valid & in_ready & ~flush.
REQ-027 A non-MUL operation SHALL have 1-cycle latency: accepted at edge k, alu_out, flags and out_valid=1 visible after edge k.
REQ-028 When an operation is accepted with in_ready=1 while out_valid=1 and stall_in=0, the old result SHALL be consumed and replaced at the same edge.
REQ-029 When out_valid=1 and stall_in=1, alu_out, flags and out_valid SHALL hold.
REQ-030 When a cycle ends with no acceptance and stall_in=0, out_valid SHALL go to 0.
REQ-031 The multiply FSM SHALL have states IDLE, RUN and DONE.
REQ-032 IDLE->RUN SHALL occur on acceptance of a MUL, with operands latched and the counter set to WIDTH.
REQ-033 In RUN the counter SHALL decrement once per cycle; RUN->DONE SHALL occur when the counter reaches 0.
REQ-034 DONE SHALL register the product and set out_valid, then go to IDLE; a MUL SHALL therefore take WIDTH+1 cycles from acceptance to out_valid.
REQ-035 busy SHALL be 1 in RUN and DONE; forwarded inputs SHALL be ignored after MUL acceptance.
REQ-036 flush SHALL clear out_valid at the next edge, abort RUN or DONE to IDLE, block acceptance in that cycle and leave flags unchanged.
REQ-037 When flush and stall_in are both asserted, flush SHALL win.

Reset
REQ-038 When rst_n=0, the block SHALL asynchronously force out_valid=0, alu_out=0, flags=3'b000, busy=0, FSM=IDLE and counter=0.
REQ-039 Assertion of rst_n=0 mid-multiply SHALL discard the multiply with no result produced.
REQ-040 After rst_n deasserts, in_ready SHALL be 1 in the first cycle.

Verification (WIDTH=16)
REQ-041 Saturation: ADD with in1=0x7FFF, in2=0x0001 -> after 1 edge alu_out=0x7FFF, flags={0,1,0}; SUB with in1=0x8000, in2=0x0001 -> alu_out=0x8000, V=1, N=1.
REQ-042 Forwarding: fwd_a=2'b11, mem_fwd=0x1234, wb_fwd=0x5678, fwd_b=2'b01, alu_src=1, opcode=ADD -> alu_out=0x68AC.
REQ-043 Multiply: MUL with in1=0x0003, in2=0x0005 -> in_ready=0 and busy=1 for 17 cycles, alu_out=0x000F with out_valid=1 at edge 17, then Z=0.
REQ-044 Backpressure: with a result valid, assert stall_in for 3 cycles while in_valid=1 -> alu_out and flags are stable, in_ready=0, and the next operation is accepted in the cycle stall_in drops.
REQ-045 Flush mid-MUL: flush at cycle 5 of a MUL -> busy=0 and out_valid=0 next cycle, flags hold their prior value, and a new ADD is accepted the following cycle.
REQ-046 Reset mid-MUL: rst_n low for 1 cycle -> all outputs are 0 immediately, with no late out_valid pulse afterwards.

Source files
------------

// File: rtl/ex_pipe_unit.sv
// ex_pipe_unit: EX stage with operand forwarding, saturating ALU and an iterative shift-add multiplier.
module ex_pipe_unit #(
    parameter int WIDTH  = 16,
    parameter int MUL_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] pc_in,
    input  logic [WIDTH-1:0] reg_a,
    input  logic [WIDTH-1:0] reg_b,
    input  logic [WIDTH-1:0] imm,
    input  logic [3:0]       opcode,
    input  logic             alu_src,
    input  logic             pc_switch,
    input  logic [1:0]       fwd_a,
    input  logic [1:0]       fwd_b,
    input  logic [WIDTH-1:0] mem_fwd,
    input  logic [WIDTH-1:0] wb_fwd,
    input  logic             stall_in,
    input  logic             flush,
    output logic             out_valid,
    output logic [WIDTH-1:0] alu_out,
    output logic [2:0]       flags,
    output logic             busy
);
    localparam int SW = $clog2(WIDTH);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MAXP = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MINN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   a_fwd, b_fwd, in1, in2, sum, dif, res, ma, mb, acc;
    logic [2*WIDTH-1:0] rot;
    logic [SW-1:0]      sh;
    logic               v_add, v_sub, vf, is_mul, accept;
    logic [1:0]         upd;

    assign a_fwd    = fwd_a[1] ? mem_fwd : fwd_a[0] ? wb_fwd : reg_a;
    assign b_fwd    = fwd_b[1] ? mem_fwd : fwd_b[0] ? wb_fwd : reg_b;
    assign in1      = pc_switch ? pc_in : a_fwd;
    assign in2      = alu_src ? b_fwd : imm;
    assign sh       = in2[SW-1:0];
    assign sum      = in1 + in2;
    assign dif      = in1 - in2;
    assign rot      = {in1, in1} >> sh;
    assign v_add    = (in1[WIDTH-1] == in2[WIDTH-1]) && (sum[WIDTH-1] != in1[WIDTH-1]);
    assign v_sub    = (in1[WIDTH-1] != in2[WIDTH-1]) && (dif[WIDTH-1] != in1[WIDTH-1]);
    assign vf       = (opcode == 4'd0) ? v_add : v_sub;
    assign is_mul   = (MUL_EN != 0) && (opcode == 4'd8);
    assign busy     = (state != IDLE);
    assign in_ready = ~busy & ~(out_valid & stall_in);
    assign accept   = in_valid & in_ready & ~flush;

    // upd: 0 = no flag change, 1 = Z only, 2 = Z,V,N
    always_comb begin
        res = in2;
        upd = 2'd0;
        case (opcode)
            4'd0: begin res = v_add ? (in1[WIDTH-1] ? MINN : MAXP) : sum; upd = 2'd2; end
            4'd1: begin res = v_sub ? (in1[WIDTH-1] ? MINN : MAXP) : dif; upd = 2'd2; end
            4'd2: begin res = in1 ^ in2; upd = 2'd1; end
            4'd3: begin res = in1 & in2; upd = 2'd1; end
            4'd4: begin res = in1 | in2; upd = 2'd1; end
            4'd5: begin res = in1 << sh; upd = 2'd1; end
            4'd6: begin res = $signed(in1) >>> sh; upd = 2'd1; end
            4'd7: begin res = rot[WIDTH-1:0]; upd = 2'd1; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            ma        <= '0;
            mb        <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            alu_out   <= '0;
            flags     <= 3'b000;
        end else if (flush) begin
            state     <= IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && is_mul) begin
                        state     <= RUN;
                        cnt       <= CW'(WIDTH);
                        ma        <= in1;
                        mb        <= in2;
                        acc       <= '0;
                        out_valid <= 1'b0;
                    end else if (accept) begin
                        alu_out   <= res;
                        out_valid <= 1'b1;
                        if (upd == 2'd2) flags <= {res == '0, vf, res[WIDTH-1]};
                        else if (upd == 2'd1) flags[2] <= (res == '0);
                    end else if (!stall_in) begin
                        out_valid <= 1'b0;
                    end
                end
                RUN: begin
                    acc <= acc + (mb[0] ? ma : '0);
                    ma  <= ma << 1;
                    mb  <= mb >> 1;
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) state <= DONE;
                    if (!stall_in) out_valid <= 1'b0;
                end
                default: begin
                    alu_out   <= acc;
                    flags[2]  <= (acc == '0);
                    out_valid <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ex_pipe_unit.sv
// tb_ex_pipe_unit: random and directed checks of ex_pipe_unit against an arithmetic reference model.
module tb_ex_pipe_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic [15:0] pc_in = '0, reg_a = '0, reg_b = '0, imm = '0, mem_fwd = '0, wb_fwd = '0;
    logic [3:0]  opcode = '0;
    logic        alu_src = 1'b0, pc_switch = 1'b0, stall_in = 1'b0, flush = 1'b0;
    logic [1:0]  fwd_a = '0, fwd_b = '0;
    logic        out_valid, busy;
    logic [15:0] alu_out;
    logic [2:0]  flags;

    int          total = 0, bad = 0;
    logic [2:0]  mfl = 3'b000;
    logic [15:0] mout = '0;

    ex_pipe_unit #(.WIDTH(16), .MUL_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .pc_in(pc_in), .reg_a(reg_a), .reg_b(reg_b), .imm(imm), .opcode(opcode),
        .alu_src(alu_src), .pc_switch(pc_switch), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .mem_fwd(mem_fwd), .wb_fwd(wb_fwd), .stall_in(stall_in), .flush(flush),
        .out_valid(out_valid), .alu_out(alu_out), .flags(flags), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Result of one operation from plain integer arithmetic; updates the model flags.
    function automatic logic [15:0] model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        int s, n;
        logic [15:0] r;
        n = int'(b) % 16;
        r = b;
        if (op <= 4'd1) begin
            s = (op == 4'd0) ? int'($signed(a)) + int'($signed(b)) : int'($signed(a)) - int'($signed(b));
            r = (s > 32767) ? 16'h7fff : (s < -32768) ? 16'h8000 : 16'(s);
            mfl = {r == 16'h0, (s > 32767) || (s < -32768), r[15]};
        end else if (op <= 4'd8) begin
            case (op)
                4'd2: r = a ^ b;
                4'd3: r = a & b;
                4'd4: r = a | b;
                4'd5: r = 16'(32'(a) << n);
                4'd6: r = 16'(int'($signed(a)) >>> n);
                4'd7: r = 16'((32'(a) >> n) | (32'(a) << (16 - n)));
                default: r = 16'(32'(a) * 32'(b));
            endcase
            mfl[2] = (r == 16'h0);
        end
        return r;
    endfunction

    task automatic drive(input logic [3:0] op, input logic [15:0] ra, rb, im, pc, mf, wf,
                         input logic [1:0] fa, fb, input logic as, ps);
        opcode = op; reg_a = ra; reg_b = rb; imm = im; pc_in = pc; mem_fwd = mf; wb_fwd = wf;
        fwd_a = fa; fwd_b = fb; alu_src = as; pc_switch = ps; in_valid = 1'b1;
    endtask

    task automatic do_op(input logic [3:0] op, input logic [15:0] ra, rb, im, pc, mf, wf,
                         input logic [1:0] fa, fb, input logic as, ps);
        logic [15:0] x, y;
        int n, rdy_seen;
        drive(op, ra, rb, im, pc, mf, wf, fa, fb, as, ps);
        x = fa[1] ? mf : fa[0] ? wf : ra;
        y = fb[1] ? mf : fb[0] ? wf : rb;
        #1 chk("accept_ready", in_ready, 1);
        mout = model(op, ps ? pc : x, as ? y : im);
        @(negedge clk);
        in_valid = 1'b0;
        if (op == 4'd8) begin
            n = 0;
            rdy_seen = 0;
            while (busy && n < 40) begin
                if (in_ready) rdy_seen++;
                reg_a = 16'($urandom); reg_b = 16'($urandom); mem_fwd = 16'($urandom);
                wb_fwd = 16'($urandom); imm = 16'($urandom); in_valid = 1'($urandom);
                n++;
                @(negedge clk);
            end
            in_valid = 1'b0;
            chk("mul_busy_cycles", n, 17);
            chk("mul_ready_low", rdy_seen, 0);
        end
        chk("res_valid", out_valid, 1);
        chk("res_value", alu_out, mout);
        chk("res_flags", flags, mfl);
    endtask

    initial begin
        int late;
        repeat (2) @(negedge clk);
        chk("rst_out", alu_out, 0);
        chk("rst_flags", flags, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        #1 chk("rst_ready", in_ready, 1);

        do_op(4'd0, 16'h7fff, 16'h0001, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0);
        chk("sat_add_val", alu_out, 16'h7fff);
        chk("sat_add_flags", flags, 3'b010);
        do_op(4'd1, 16'h8000, 16'h0001, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0);
        chk("sat_sub_val", alu_out, 16'h8000);
        chk("sat_sub_flags", flags, 3'b011);
        do_op(4'd0, 16'h1111, 16'h2222, 16'h9999, 0, 16'h1234, 16'h5678, 2'b11, 2'b01, 1, 0);
        chk("fwd_val", alu_out, 16'h68ac);
        do_op(4'd5, 16'hbeef, 16'h0010, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0);
        chk("shift_zero", alu_out, 16'hbeef);
        do_op(4'd8, 16'h0003, 16'h0005, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0);
        chk("mul_val", alu_out, 16'h000f);
        chk("mul_z", flags[2], 0);

        // backpressure with a pending operation
        do_op(4'd2, 16'h00ff, 16'h0f0f, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0);
        stall_in = 1'b1;
        drive(4'd0, 16'h0001, 16'h0002, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0);
        repeat (3) begin
            #1 chk("stall_ready", in_ready, 0);
            @(negedge clk);
            chk("stall_hold_val", alu_out, mout);
            chk("stall_hold_flags", flags, mfl);
            chk("stall_hold_valid", out_valid, 1);
        end
        stall_in = 1'b0;
        do_op(4'd0, 16'h0001, 16'h0002, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0);
        chk("stall_next", alu_out, 16'h0003);

        // flush beats stall
        stall_in = 1'b1; flush = 1'b1;
        @(negedge clk);
        stall_in = 1'b0; flush = 1'b0;
        chk("flush_stall_valid", out_valid, 0);
        chk("flush_stall_flags", flags, mfl);
        // flush blocks acceptance
        drive(4'd1, 16'h0000, 16'h0000, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0);
        flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_block_valid", out_valid, 0);
        chk("flush_block_flags", flags, mfl);

        // flush at cycle 5 of a multiply
        do_op(4'd0, 16'h7fff, 16'h7fff, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0);
        drive(4'd8, 16'h0007, 16'h0009, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("flush_mul_busy_before", busy, 1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_mul_busy", busy, 0);
        chk("flush_mul_valid", out_valid, 0);
        chk("flush_mul_flags", flags, 3'b010);
        do_op(4'd0, 16'h0010, 16'h0020, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0);

        // reset in the middle of a multiply
        drive(4'd8, 16'h0011, 16'h0013, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_out", alu_out, 0);
        chk("arst_flags", flags, 0);
        chk("arst_valid", out_valid, 0);
        chk("arst_busy", busy, 0);
        mfl = 3'b000;
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("arst_ready", in_ready, 1);
        late = 0;
        repeat (25) begin
            @(negedge clk);
            if (out_valid) late++;
        end
        chk("arst_no_late", late, 0);

        for (int i = 0; i < 60; i++) begin
            do_op(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom), 16'($urandom),
                  16'($urandom), 16'($urandom), 16'($urandom), 2'($urandom), 2'($urandom),
                  1'($urandom), 1'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                @(negedge clk);
                chk("idle_drop", out_valid, 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
